// File: rtl/err_watchdog.sv
// Simulation watchdog: flags unit errors, retirement hangs and commit-after-halt
// as one sticky registered err plus cause. Define WDOG_STATS_EN to build cycle/retire counters.
module err_watchdog #(
    parameter int TIMEOUT = 1024,
    parameter int ERR_W   = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  logic             halt,
    input  logic [ERR_W-1:0] err_in,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [ERR_W-1:0] err_unit,
    output logic             done,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_UNIT  = 3'd1;
    localparam logic [2:0] CODE_HANG  = 3'd2;
    localparam logic [2:0] CODE_AHALT = 3'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic              err_s;
    logic [2:0]        code_s;
    logic [ERR_W-1:0]  unit_s;
    logic              done_s;
    logic [IDLE_W-1:0] idle_r, idle_s;

    // Next-state and next-output decode; the first cause to arrive wins.
    always_comb begin
        state_s = state_r;
        err_s   = err;
        code_s  = err_code;
        unit_s  = err_unit;
        done_s  = done;
        idle_s  = idle_r;
        case (state_r)
            ST_RUN: begin
                if (err_in != {ERR_W{1'b0}}) begin
                    state_s = ST_ERROR;
                    err_s   = 1'b1;
                    code_s  = CODE_UNIT;
                    unit_s  = err_in;
                end else if (halt) begin
                    state_s = ST_HALTED;
                    done_s  = 1'b1;
                end else if (commit) begin
                    idle_s = {IDLE_W{1'b0}};
                end else if (idle_r == IDLE_LAST) begin
                    // idle stops here, so it saturates rather than wrapping
                    state_s = ST_ERROR;
                    err_s   = 1'b1;
                    code_s  = CODE_HANG;
                end else begin
                    idle_s = idle_r + IDLE_W'(1);
                end
            end
            ST_HALTED: begin
                if (commit) begin
                    state_s = ST_ERROR;
                    err_s   = 1'b1;
                    code_s  = CODE_AHALT;
                    done_s  = 1'b0;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            ST_ERROR: begin
                state_s = ST_ERROR;
            end
            default: begin
                state_s = ST_ERROR;
                err_s   = 1'b1;
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_RUN;
            err      <= 1'b0;
            err_code <= CODE_NONE;
            err_unit <= {ERR_W{1'b0}};
            done     <= 1'b0;
            idle_r   <= {IDLE_W{1'b0}};
        end else begin
            state_r  <= state_s;
            err      <= err_s;
            err_code <= code_s;
            err_unit <= unit_s;
            done     <= done_s;
            idle_r   <= idle_s;
        end
    end

`ifdef WDOG_STATS_EN
    logic [CNT_W-1:0] cyc_r;
    logic [CNT_W-1:0] ret_r;

    // Statistics: every RUN cycle counts; retirement counts unless a unit error preempts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_r <= {CNT_W{1'b0}};
            ret_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            cyc_r <= cyc_r + CNT_W'(1);
            if (commit && (err_in == {ERR_W{1'b0}})) begin
                ret_r <= ret_r + CNT_W'(1);
            end else begin
                ret_r <= ret_r;
            end
        end else begin
            cyc_r <= cyc_r;
            ret_r <= ret_r;
        end
    end

    assign cyc_cnt = cyc_r;
    assign ret_cnt = ret_r;
`else
    assign cyc_cnt = {CNT_W{1'b0}};
    assign ret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_err_watchdog.sv
// Scoreboard bench for err_watchdog (TIMEOUT=16). Counter expectations
// follow WDOG_STATS_EN, so the same bench serves both builds.
module tb_err_watchdog;

    logic        clk;
    logic        rst;
    logic        commit;
    logic        halt;
    logic [3:0]  err_in;
    logic        err;
    logic [2:0]  err_code;
    logic [3:0]  err_unit;
    logic        done;
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic        err;
        logic [2:0]  code;
        logic [3:0]  unit;
        logic        done;
        logic [31:0] cyc;
        logic [31:0] ret;
        bit          chk_cnt;
    } exp_t;

    exp_t sb_q[$];

    err_watchdog #(.TIMEOUT(16), .ERR_W(4), .CNT_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .commit   (commit),
        .halt     (halt),
        .err_in   (err_in),
        .err      (err),
        .err_code (err_code),
        .err_unit (err_unit),
        .done     (done),
        .cyc_cnt  (cyc_cnt),
        .ret_cnt  (ret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic e, input logic [2:0] c,
                            input logic [3:0] u, input logic d,
                            input logic [31:0] cyc, input logic [31:0] ret, input bit chk_cnt);
        exp_t x;
        x.tag = tag; x.err = e; x.code = c; x.unit = u; x.done = d;
`ifdef WDOG_STATS_EN
        x.cyc = cyc; x.ret = ret;
`else
        x.cyc = 32'd0; x.ret = 32'd0;
`endif
        x.chk_cnt = chk_cnt;
        sb_q.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check_val({x.tag, ".err"},  {31'd0, err},      {31'd0, x.err});
            check_val({x.tag, ".code"}, {29'd0, err_code}, {29'd0, x.code});
            check_val({x.tag, ".unit"}, {28'd0, err_unit}, {28'd0, x.unit});
            check_val({x.tag, ".done"}, {31'd0, done},     {31'd0, x.done});
            if (x.chk_cnt) begin
                check_val({x.tag, ".cyc"}, cyc_cnt, x.cyc);
                check_val({x.tag, ".ret"}, ret_cnt, x.ret);
            end
        end
    endtask

    // Called at posedge+1: drive inputs, wait one edge, compare queued expectations.
    task automatic step(input logic c, input logic h, input logic [3:0] e);
        commit = c; halt = h; err_in = e;
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; commit = 1'b0; halt = 1'b0; err_in = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        push_exp({tag, ".rst"}, 1'b0, 3'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        drain();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; commit = 1'b0; halt = 1'b0; err_in = 4'd0;

        // Clean run: 50 commits then halt with commit
        do_reset("s1");
        for (int i = 0; i < 50; i++) begin
            if (i == 49) push_exp("s1.run", 1'b0, 3'd0, 4'd0, 1'b0, 32'd50, 32'd50, 1'b1);
            step(1'b1, 1'b0, 4'd0);
        end
        push_exp("s1.halt", 1'b0, 3'd0, 4'd0, 1'b1, 32'd51, 32'd51, 1'b1);
        step(1'b1, 1'b1, 4'd0);
        push_exp("s1.frozen", 1'b0, 3'd0, 4'd0, 1'b1, 32'd51, 32'd51, 1'b1);
        step(1'b0, 1'b1, 4'b1111);

        // Hang with a restart on idle cycle 15
        do_reset("s2a");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 14; i++) begin
            if (i == 13) push_exp("s2a.idle14", 1'b0, 3'd0, 4'd0, 1'b0, 32'd24, 32'd10, 1'b1);
            step(1'b0, 1'b0, 4'd0);
        end
        push_exp("s2a.restart", 1'b0, 3'd0, 4'd0, 1'b0, 32'd25, 32'd11, 1'b1);
        step(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 15; i++) begin
            if (i == 14) push_exp("s2a.idle15", 1'b0, 3'd0, 4'd0, 1'b0, 32'd40, 32'd11, 1'b1);
            step(1'b0, 1'b0, 4'd0);
        end
        push_exp("s2a.hang", 1'b1, 3'd2, 4'd0, 1'b0, 32'd41, 32'd11, 1'b1);
        step(1'b0, 1'b0, 4'd0);
        push_exp("s2a.hold", 1'b1, 3'd2, 4'd0, 1'b0, 32'd41, 32'd11, 1'b1);
        step(1'b1, 1'b1, 4'b1000);

        // Plain hang: 17th edge after the last commit is driven
        do_reset("s2b");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 15; i++) begin
            if (i == 14) push_exp("s2b.idle15", 1'b0, 3'd0, 4'd0, 1'b0, 32'd25, 32'd10, 1'b1);
            step(1'b0, 1'b0, 4'd0);
        end
        push_exp("s2b.hang", 1'b1, 3'd2, 4'd0, 1'b0, 32'd26, 32'd10, 1'b1);
        step(1'b0, 1'b0, 4'd0);

        // Unit error, later error does not overwrite
        do_reset("s3");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0);
        push_exp("s3.unit", 1'b1, 3'd1, 4'b0100, 1'b0, 32'd4, 32'd3, 1'b1);
        step(1'b0, 1'b0, 4'b0100);
        push_exp("s3.later", 1'b1, 3'd1, 4'b0100, 1'b0, 32'd4, 32'd3, 1'b1);
        step(1'b0, 1'b0, 4'b0001);
        push_exp("s3.hold", 1'b1, 3'd1, 4'b0100, 1'b0, 32'd4, 32'd3, 1'b1);
        step(1'b1, 1'b1, 4'd0);

        // Commit after halt
        do_reset("s4a");
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 4'd0);
        push_exp("s4a.halt", 1'b0, 3'd0, 4'd0, 1'b1, 32'd3, 32'd2, 1'b1);
        step(1'b0, 1'b1, 4'd0);
        push_exp("s4a.wait", 1'b0, 3'd0, 4'd0, 1'b1, 32'd3, 32'd2, 1'b1);
        step(1'b0, 1'b0, 4'd0);
        push_exp("s4a.ahalt", 1'b1, 3'd3, 4'd0, 1'b0, 32'd3, 32'd2, 1'b1);
        step(1'b1, 1'b0, 4'd0);

        // Halt and unit error together: unit error wins
        do_reset("s4b");
        push_exp("s4b.both", 1'b1, 3'd1, 4'b0010, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 4'b0010);
        push_exp("s4b.hold", 1'b1, 3'd1, 4'b0010, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0);

        // Asynchronous reset mid-cycle while in ERROR
        #2;
        rst = 1'b1;
        #1;
        push_exp("s5.async", 1'b0, 3'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) push_exp("s5.rerun", 1'b0, 3'd0, 4'd0, 1'b0, 32'd5, 32'd5, 1'b1);
            step(1'b1, 1'b0, 4'd0);
        end

        if (sb_q.size() != 0) check_val("sb.leftover", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
